wb_ram_slave_pipelined_param: RTL and testbench

//   Parametrised Wishbone B4 pipelined-mode slave wrapping a single-port synchronous RAM.

---
 rtl/wb_ram_slave_pipelined_param_if.sv | 29 ++
 rtl/wb_ram_slave_pipelined_param.sv | 110 +++++++++++
 tb/tb_wb_ram_slave_pipelined_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_slave_pipelined_param_if.sv
// Wishbone B4 pipelined-mode bus bundle for wb_ram_slave_pipelined_param.
//   master modport: drives cyc/stb/we/adr/sel/dat_i, observes dat_o/ack/err/stall
//   slave modport : the reverse
interface wb_ram_slave_pipelined_param_if #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [ADR_WIDTH-1:0] adr;
  logic [SEL_WIDTH-1:0] sel;
  logic [DAT_WIDTH-1:0] dat_i;
  logic [DAT_WIDTH-1:0] dat_o;
  logic                 ack;
  logic                 err;
  logic                 stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_i,
    input  dat_o, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_i,
    output dat_o, ack, err, stall
  );
endinterface

// File: rtl/wb_ram_slave_pipelined_param.sv
// Parametrised Wishbone B4 pipelined slave around a single-port synchronous RAM.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (RAM contents are not reset)
//   bus    : slave modport of wb_ram_slave_pipelined_param_if
//            (cyc, stb, we, adr, sel, dat_i in; dat_o, ack, err, stall out)
// A request is accepted on cyc & stb & ~stall. Its response (ack, or err for an
// address beyond the RAM) appears LATENCY cycles after the accept edge, in order.
// Dropping cyc discards every in-flight response; committed writes stay.
module wb_ram_slave_pipelined_param #(
  parameter int ADR_WIDTH     = 32,
  parameter int DAT_WIDTH     = 32,
  parameter int SEL_WIDTH     = DAT_WIDTH / 8,
  parameter int MEM_ADR_WIDTH = 16,
  parameter int LATENCY       = 2,
  parameter int MAX_OUT       = 2
) (
  input logic                          clk,
  input logic                          rst_n,
  wb_ram_slave_pipelined_param_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int DEPTH = 1 << MEM_ADR_WIDTH;

  logic [DAT_WIDTH-1:0] mem [DEPTH];

  logic [LATENCY-1:0]                pipe_vld, pipe_err, pipe_rd;
  logic [LATENCY-1:0]                vld_nxt, err_nxt, rd_nxt;
  logic [LATENCY-1:0][DAT_WIDTH-1:0] pipe_dat, dat_nxt;
  logic [CNT_W-1:0]                  outstanding;

  logic [MEM_ADR_WIDTH-1:0] mem_adr;
  logic [ADR_WIDTH-1:0]     adr_hi;
  logic [DAT_WIDTH-1:0]     rd_word, wr_word;
  logic                     in_range, accept, stall_int, resp_vld, ack_int;

  assign mem_adr   = bus.adr[MEM_ADR_WIDTH-1:0];
  // Shifting out the RAM index leaves only the bits that must be zero.
  assign adr_hi    = bus.adr >> MEM_ADR_WIDTH;
  assign in_range  = (adr_hi == '0);

  assign stall_int = bus.cyc & (outstanding == CNT_W'(MAX_OUT));
  assign accept    = bus.cyc & bus.stb & ~stall_int;

  // The tail stage is the response; cyc gates it so an abort silences it at once.
  assign resp_vld  = bus.cyc & pipe_vld[LATENCY-1];
  assign ack_int   = resp_vld & ~pipe_err[LATENCY-1];

  assign bus.stall = stall_int;
  assign bus.ack   = ack_int;
  assign bus.err   = resp_vld & pipe_err[LATENCY-1];
  assign bus.dat_o = (ack_int && pipe_rd[LATENCY-1]) ? pipe_dat[LATENCY-1] : '0;

  // Byte-lane merge: unselected lanes keep the current RAM word.
  always_comb begin
    rd_word = mem[mem_adr];
    wr_word = rd_word;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (bus.sel[i]) wr_word[8*i +: 8] = bus.dat_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.we && in_range) mem[mem_adr] <= wr_word;
  end

  // Stage 0 is loaded at the accept edge; the rest is a plain shift.
  always_comb begin
    vld_nxt    = '0;
    err_nxt    = '0;
    rd_nxt     = '0;
    dat_nxt    = pipe_dat;
    vld_nxt[0] = accept;
    err_nxt[0] = ~in_range;
    rd_nxt[0]  = ~bus.we;
    if (accept && !bus.we && in_range) dat_nxt[0] = rd_word;
    for (int k = 1; k < LATENCY; k++) begin
      vld_nxt[k] = pipe_vld[k-1];
      err_nxt[k] = pipe_err[k-1];
      rd_nxt[k]  = pipe_rd[k-1];
      dat_nxt[k] = pipe_dat[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_dat <= dat_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld    <= '0;
      pipe_err    <= '0;
      pipe_rd     <= '0;
      outstanding <= '0;
    end else if (!bus.cyc) begin
      pipe_vld    <= '0;
      outstanding <= '0;
    end else begin
      pipe_vld <= vld_nxt;
      pipe_err <= err_nxt;
      pipe_rd  <= rd_nxt;
      case ({accept, resp_vld})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_slave_pipelined_param.sv
// Directed bench: dut_a uses LATENCY=2/MAX_OUT=2, dut_b uses LATENCY=3/MAX_OUT=2.
// One shared set of master signals is steered to either DUT by use_b.
module tb_wb_ram_slave_pipelined_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_ram_slave_pipelined_param_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) bus_a ();
  wb_ram_slave_pipelined_param_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) bus_b ();

  wb_ram_slave_pipelined_param #(
    .ADR_WIDTH(32), .DAT_WIDTH(32), .MEM_ADR_WIDTH(16), .LATENCY(2), .MAX_OUT(2)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

  wb_ram_slave_pipelined_param #(
    .ADR_WIDTH(32), .DAT_WIDTH(32), .MEM_ADR_WIDTH(16), .LATENCY(3), .MAX_OUT(2)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic        m_cyc, m_stb, m_we, use_b;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;

  assign bus_a.cyc   = m_cyc & ~use_b;
  assign bus_a.stb   = m_stb & ~use_b;
  assign bus_a.we    = m_we;
  assign bus_a.adr   = m_adr;
  assign bus_a.sel   = m_sel;
  assign bus_a.dat_i = m_dat;
  assign bus_b.cyc   = m_cyc & use_b;
  assign bus_b.stb   = m_stb & use_b;
  assign bus_b.we    = m_we;
  assign bus_b.adr   = m_adr;
  assign bus_b.sel   = m_sel;
  assign bus_b.dat_i = m_dat;

  logic        r_ack, r_err, r_stall;
  logic [31:0] r_dat;
  assign r_ack   = use_b ? bus_b.ack   : bus_a.ack;
  assign r_err   = use_b ? bus_b.err   : bus_a.err;
  assign r_stall = use_b ? bus_b.stall : bus_a.stall;
  assign r_dat   = use_b ? bus_b.dat_o : bus_a.dat_o;

  int total = 0;
  int bad   = 0;
  int q_acc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request, then watch 8 cycles: first response cycle, count, kind, data.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output int lat, output int nresp,
                      output logic was_err, output logic [31:0] rdat);
    lat = 0; nresp = 0; was_err = 1'b0; rdat = '0;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_sel = sel; m_dat = dat;
    @(posedge clk); #1;
    m_stb = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (r_ack || r_err) begin
        nresp++;
        if (lat == 0) begin
          lat = n; was_err = r_err; rdat = r_dat;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat, nr, cnt;
    int cyc_cnt, outst, max_o, n_acc, n_rsp, stall_cyc, lat_b;
    logic e, acc_now, rsp_now;
    logic [31:0] d;

    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_sel = '0; m_dat = '0; use_b = 0;

    // reset state, with cyc high to show stall stays low
    #2 m_cyc = 1'b1;
    #1;
    check("rst_ack", bus_a.ack, 0);
    check("rst_err", bus_a.err, 0);
    check("rst_stall", bus_a.stall, 0);
    check("rst_dat", bus_a.dat_o, 0);
    m_cyc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // T2 write then read, latency 2
    xfer(1'b1, 32'h10, 4'hF, 32'h1234_5678, lat, nr, e, d);
    check("t2_wr_lat", lat, 2);
    check("t2_wr_nresp", nr, 1);
    check("t2_wr_dat0", d, 0);
    xfer(1'b0, 32'h10, 4'hF, 32'h0, lat, nr, e, d);
    check("t2_rd_lat", lat, 2);
    check("t2_rd_err", e, 0);
    check("t2_rd_dat", d, 32'h1234_5678);

    // T3 byte lanes
    xfer(1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF, lat, nr, e, d);
    xfer(1'b1, 32'h20, 4'b1010, 32'hAB00_CD00, lat, nr, e, d);
    check("t3_wr_lat", lat, 2);
    xfer(1'b0, 32'h20, 4'hF, 32'h0, lat, nr, e, d);
    check("t3_rd_dat", d, 32'hABFF_CDFF);

    // T5 out of range write must not alias onto word 0
    xfer(1'b1, 32'h0, 4'hF, 32'h0000_BEEF, lat, nr, e, d);
    xfer(1'b1, 32'h0001_0000, 4'hF, 32'h0000_DEAD, lat, nr, e, d);
    check("t5_err", e, 1);
    check("t5_err_lat", lat, 2);
    check("t5_err_nresp", nr, 1);
    check("t5_err_dat", d, 0);
    xfer(1'b0, 32'h0, 4'hF, 32'h0, lat, nr, e, d);
    check("t5_rd_err", e, 0);
    check("t5_rd_dat", d, 32'h0000_BEEF);

    // T6 abort two reads with a one-cycle cyc drop
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h10;
    @(posedge clk); @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    check("t6_gated_ack", bus_a.ack, 0);
    @(posedge clk); #1;
    m_cyc = 1'b1;
    @(negedge clk);
    check("t6_late_ack", r_ack, 0);
    check("t6_late_err", r_err, 0);
    check("t6_stall_clr", r_stall, 0);
    xfer(1'b0, 32'h20, 4'hF, 32'h0, lat, nr, e, d);
    check("t6_new_nresp", nr, 1);
    check("t6_new_lat", lat, 2);
    check("t6_new_dat", d, 32'hABFF_CDFF);

    // T1 reset with two reads in flight
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h20;
    @(posedge clk); @(posedge clk); #1;
    m_stb = 1'b0;
    check("t1_stall_pre", r_stall, 1);
    check("t1_ack_pre", r_ack, 1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_ack", r_ack, 0);
    check("t1_rst_err", r_err, 0);
    check("t1_rst_stall", r_stall, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (r_ack || r_err) cnt++;
    end
    check("t1_no_resp", cnt, 0);
    m_cyc = 1'b0;

    // preload dut_b, latency 3
    use_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xfer(1'b1, 32'(i), 4'hF, 32'hB000_0000 + 32'(i), lat, nr, e, d);
      check("t4_pre_lat", lat, 3);
    end

    // T4 six back-to-back reads held on stb against MAX_OUT=2, LATENCY=3
    cyc_cnt = 0; outst = 0; max_o = 0; n_acc = 0; n_rsp = 0; stall_cyc = 0;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0;
    for (int t = 0; t < 40 && n_rsp < 6; t++) begin
      @(negedge clk);
      acc_now = m_stb & ~r_stall;
      rsp_now = r_ack | r_err;
      check("t4_stall", r_stall, (outst == 2));
      if (r_stall) stall_cyc++;
      if (rsp_now) begin
        check("t4_no_err", r_err, 0);
        check("t4_rsp_pending", (q_acc.size() != 0), 1);
        if (q_acc.size() != 0) begin
          lat_b = cyc_cnt - q_acc.pop_front() + 1;
          check("t4_lat", lat_b, 3);
        end
        check("t4_dat", r_dat, 32'hB000_0000 + 32'(n_rsp));
        n_rsp++;
      end
      @(posedge clk);
      cyc_cnt++;
      if (acc_now) begin
        q_acc.push_back(cyc_cnt);
        n_acc++;
        outst++;
      end
      if (rsp_now) outst--;
      if (outst > max_o) max_o = outst;
      #1;
      if (n_acc == 6) m_stb = 1'b0;
      else m_adr = 32'(n_acc);
    end
    check("t4_n_acc", n_acc, 6);
    check("t4_n_rsp", n_rsp, 6);
    check("t4_max_out", max_o, 2);
    check("t4_stalled", (stall_cyc != 0), 1);
    m_cyc = 1'b0;
    m_stb = 1'b0;

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
